// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   ch_w()               : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index width; never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        if (num_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational arbiter with fixed-priority and round-robin modes.
// Ports:
//   req       in  NUM_CH  request vector (one bit per channel)
//   ptr       in  CH_W    round-robin start channel (used when mode = MODE_RR)
//   mode      in  1       MODE_FIXED: lowest index wins; MODE_RR: search from ptr
//   grant     out NUM_CH  one-hot grant, all zero when no request
//   grant_idx out CH_W    encoded index of the granted channel (0 if none)
//   grant_any out 1       some channel is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);

    int cand_s;

    // Walk the channels starting at ptr (round-robin) or 0 (fixed); first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_s    = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            if (mode == MODE_RR) begin
                cand_s = int'(ptr) + off;
            end else begin
                cand_s = off;
            end
            // ptr < NUM_CH, so a single subtraction completes the wrap.
            if (cand_s >= NUM_CH) begin
                cand_s = cand_s - NUM_CH;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = CH_W'(cand_s);
                grant_any     = 1'b1;
            end else begin
                grant_any     = grant_any;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_rr_stream.sv
// -----------------------------------------------------------------------------
// mux_rr_stream
// N-channel valid/ready stream multiplexer with a one-entry registered output.
// Ports:
//   clk       in  1              rising-edge clock
//   rst_n     in  1              asynchronous active-low reset
//   mode      in  1              0 = fixed priority (ch0 highest), 1 = round-robin
//   in_valid  in  NUM_CH         per-channel valid
//   in_ready  out NUM_CH         per-channel ready (combinational, depends on in_valid)
//   in_data   in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   out_valid out 1              output register holds a word
//   out_ready in  1              consumer accepts the word
//   out_data  out DATA_W         registered data
//   out_ch    out CH_W           source channel of out_data
// -----------------------------------------------------------------------------
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch
);

    logic [NUM_CH-1:0] grant_s;
    logic [CH_W-1:0]   grant_idx_s;
    logic              grant_any_s;
    logic              load_en_s;
    logic              in_xfer_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [CH_W-1:0]   ptr_next_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [CH_W-1:0]   out_ch_r;
    logic [CH_W-1:0]   ptr_r;

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_r),
        .mode      (mode),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Handshake control: register can load when empty or draining this cycle.
    // rst_n gates ready so upstream sees no transfer while reset is asserted.
    always_comb begin
        load_en_s = ~out_valid_r | out_ready;
        in_ready  = grant_s & {NUM_CH{load_en_s & rst_n}};
        in_xfer_s = grant_any_s & load_en_s & rst_n;
    end

    // Selected channel's data and the pointer value that follows it.
    always_comb begin
        sel_data_s = in_data[int'(grant_idx_s)*DATA_W +: DATA_W];
        if (grant_idx_s == CH_W'(NUM_CH - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + CH_W'(1);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            ptr_r       <= '0;
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_ch_r    <= grant_idx_s;
            ptr_r       <= ptr_next_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule : mux_rr_stream

// File: tb/tb_mux_rr_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_stream
// Self-checking bench: directed scenarios plus random traffic, checked against
// a transaction-level reference model of the multiplexer.
// -----------------------------------------------------------------------------
module tb_mux_rr_stream;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     mode;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;

    int n_cmp;
    int n_err;

    // Reference model state
    bit       m_valid;
    int       m_data;
    int       m_ch;
    int       m_ptr;

    mux_rr_stream #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel that the arbitration rules select, or -1 if none is valid.
    function automatic int model_winner(input bit m, input logic [NUM_CH-1:0] v, input int p);
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = m ? (p + k) % NUM_CH : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int chan_data(input int c);
        logic [NUM_CH*DATA_W-1:0] d;
        d = in_data;
        return int'(d[c*DATA_W +: DATA_W]);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        check_eq({tag, ".out_data"},  int'(out_data),  m_data);
        check_eq({tag, ".out_ch"},    int'(out_ch),    m_ch);
    endtask

    // One clock cycle. Entered just after a negedge; leaves just after the next one.
    task automatic run_cycle(input string tag, input bit m, input logic [NUM_CH-1:0] v,
                             input bit ord);
        int  win;
        bit  load;
        logic [NUM_CH-1:0] exp_rdy;
        mode      = m;
        in_valid  = v;
        out_ready = ord;
        #1;
        win  = model_winner(m, v, m_ptr);
        load = !m_valid || ord;
        exp_rdy = '0;
        if (load && win >= 0) exp_rdy[win] = 1'b1;
        check_eq({tag, ".in_ready"}, int'(in_ready), int'(exp_rdy));
        @(posedge clk);
        if (load && win >= 0) begin
            m_valid = 1'b1;
            m_data  = chan_data(win);
            m_ch    = win;
            m_ptr   = (win + 1) % NUM_CH;
        end else if (m_valid && ord) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_data_base(input int base);
        for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = DATA_W'(base + c);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();

        // Reset held with active inputs.
        rst_n     = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data_base(8'h50);
        repeat (3) @(negedge clk);
        check_eq("rst.in_ready", int'(in_ready), 0);
        check_outputs("rst");
        rst_n = 1'b1;

        // First word appears one cycle after its transfer.
        run_cycle("first", 1'b0, 4'b0100, 1'b1);
        check_eq("first.ch", int'(out_ch), 2);

        // Fixed priority: ch1 beats ch3 every cycle.
        in_data = '0;
        in_data[1*DATA_W +: DATA_W] = 8'h11;
        in_data[3*DATA_W +: DATA_W] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            run_cycle("fixed", 1'b0, 4'b1010, 1'b1);
            check_eq("fixed.data", int'(out_data), 8'h11);
        end

        // Round-robin rotation; ptr is 2 after the fixed phase, so drain once
        // through ch3 to realign the rotation to start at 0.
        set_data_base(8'hA0);
        run_cycle("rr_align", 1'b1, 4'b1000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_cycle("rr", 1'b1, 4'b1111, 1'b1);
            check_eq("rr.seq_ch", int'(out_ch), i % NUM_CH);
            check_eq("rr.seq_data", int'(out_data), 8'hA0 + (i % NUM_CH));
        end

        // Backpressure: held word (ch3) stays, then drains while ch0 loads.
        for (int i = 0; i < 3; i++) begin
            run_cycle("bp_hold", 1'b1, 4'b1111, 1'b0);
            check_eq("bp_hold.ch", int'(out_ch), 3);
        end
        run_cycle("bp_release", 1'b1, 4'b1111, 1'b1);
        check_eq("bp_release.ch", int'(out_ch), 0);

        // Wrap and sparse: move ptr to 3, grant ch0, then ch1 from ptr=1, then idle.
        run_cycle("wrap_a", 1'b1, 4'b0100, 1'b1);
        run_cycle("wrap_b", 1'b1, 4'b0001, 1'b1);
        check_eq("wrap.ch0", int'(out_ch), 0);
        run_cycle("wrap_c", 1'b1, 4'b0011, 1'b1);
        check_eq("wrap.ptr1", int'(out_ch), 1);
        run_cycle("idle", 1'b1, 4'b0000, 1'b1);
        check_eq("idle.valid", int'(out_valid), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            in_data = {$urandom, $urandom};
            run_cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom),
                      ($urandom_range(0, 3) != 0));
        end

        // Async reset between edges during round-robin traffic.
        set_data_base(8'hC0);
        run_cycle("pre_rst", 1'b1, 4'b1111, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst.out_valid", int'(out_valid), 0);
        check_eq("arst.in_ready", int'(in_ready), 0);
        check_eq("arst.out_ch", int'(out_ch), 0);
        check_eq("arst.out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("post_rst", 1'b1, 4'b1111, 1'b1);
        check_eq("post_rst.ch0", int'(out_ch), 0);
        run_cycle("post_rst2", 1'b1, 4'b1111, 1'b1);
        check_eq("post_rst2.ch1", int'(out_ch), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_rr_stream

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output. When several inputs are valid, a fixed-priority or round-robin arbiter picks one. The chosen word goes into a one-entry output register, so the output is registered and the block can sustain one beat per cycle. It is the general successor of the 2:1 select cell, used wherever several producers share one consumer.

Parameters:
NUM_CH, 4, number of input channels; must be ≥ 2.
DATA_W, 8, data width per channel in bits.
CH_W, $clog2(NUM_CH), derived localparam; width of the channel index. Not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = fixed priority (ch0 highest); 1 = round-robin
in_valid  in  NUM_CH  per-channel valid
in_ready  out  NUM_CH  per-channel ready (combinational)
in_data  in  NUM_CH*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W]
out_valid  out  1  output register holds a word
out_ready  in  1  consumer accepts the word
out_data  out  DATA_W  registered data
out_ch  out  CH_W  index of the channel that out_data came from

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
- load_en = ~out_valid | out_ready. The output register can take a new word when it is empty or is being drained this cycle.
- Grant logic (combinational, one-hot, at most one bit set):
  - mode=0: lowest-index valid channel wins.
  - mode=1: search starts at ptr and goes upward with wrap; the first valid channel wins.
- in_ready[i] = grant[i] & load_en. Every other channel sees ready=0. in_ready depends on in_valid, so producers must not make in_valid depend on in_ready.
- Input transfer on channel k: in_valid[k] & in_ready[k]. At the next edge: out_data <= in_data[k], out_ch <= k, out_valid <= 1, ptr <= (k==NUM_CH-1) ? 0 : k+1.
  - ptr updates in both modes but is used only in mode 1.
- Output transfer: out_valid & out_ready.
  - If there is no input transfer in the same cycle: out_valid <= 0. out_data and out_ch hold their last values.
  - If there is an input transfer in the same cycle: the register reloads and out_valid stays 1. This is back-to-back operation at full throughput.
- Latency: 1 cycle from input transfer to out_valid.
- Backpressure: out_valid=1 & out_ready=0 drives all in_ready=0. The register holds unchanged; no data is lost or duplicated.
- No valid inputs: no grant, ptr holds.
- A mode change is combinational and applies to the arbitration in that same cycle. ptr is not reset by a mode change.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,…,NUM_CH-1,0,… with one grant per cycle.
- Reset mid-operation: any word held in the output register is dropped. Upstream data is untouched because in_ready falls to 0 immediately.

Decomposition:
- Shared package mux_pkg holds the MODE_FIXED=1'b0 and MODE_RR=1'b1 constants and a helper function for the channel index width.
- Sub-module rr_arbiter (parameter NUM_CH) is natural. Inputs: req, ptr, mode. Output: one-hot grant plus the encoded index. It is purely combinational and is instantiated once.
- The top level holds load_en, the output register and ptr.

Test Plan:
1. Reset: hold rst_n=0 with inputs active -> out_valid=0, out_data=0, out_ch=0, in_ready=0000. Release -> first accepted word appears 1 cycle after its transfer.
2. Fixed priority: mode=0, in_valid=1010, ch1=0x11, ch3=0x33, out_ready=1 -> ch1 granted every cycle; out_data=0x11, out_ch=1; in_ready[3]=0 throughout.
3. Round-robin: mode=1, in_valid=1111, data=0xA0+ch, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; out_data sequence 0xA0..0xA3 repeated; out_valid stays high.
4. Backpressure: mode=1, out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0000. Raise out_ready -> the held word drains and the next channel after it loads in the same cycle.
5. Wrap and sparse: mode=1, ptr=3, in_valid=0001 -> ch0 granted, ptr becomes 1. Then in_valid=0000 with out_ready=1 -> out_valid drops to 0 after one cycle.
6. Async reset mid-stream: assert rst_n between clock edges during round-robin traffic -> out_valid drops immediately without a clock edge, ptr=0. After release, arbitration restarts from ch0.
